// File: rtl/ifetch_stage.sv
// Instruction fetch stage: one outstanding memory request feeding a small instruction queue,
// with redirect-driven flush and a kill state that swallows the stale in-flight response.
//
// state | meaning
// IDLE  | no request outstanding; may issue when the queue has room
// WAIT  | request accepted, response will be enqueued
// KILL  | request accepted before a redirect, response will be discarded
module ifetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          QDEPTH   = 2
) (
   input  logic        clock,
   input  logic        reset,
   output logic        io_imem_req_valid,
   input  logic        io_imem_req_ready,
   output logic [31:0] io_imem_req_addr,
   input  logic        io_imem_resp_valid,
   input  logic [31:0] io_imem_resp_data,
   input  logic        io_redirect_valid,
   input  logic [31:0] io_redirect_target,
   output logic        io_inst_valid,
   input  logic        io_inst_ready,
   output logic [31:0] io_inst_pc,
   output logic [31:0] io_inst_bits
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      KILL = 2'd2
   } state_t;

   state_t        state;
   logic [31:0]   pc;
   logic [31:0]   inflight_pc;
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic [31:0]   q_pc   [QDEPTH];
   logic [31:0]   q_bits [QDEPTH];

   logic req_fire;
   logic enq;
   logic deq;

   // Gated by reset so no request is visible while reset is held.
   assign io_imem_req_valid = reset && (state == IDLE) && (count < CW'(QDEPTH))
                              && !io_redirect_valid;
   assign io_imem_req_addr  = pc;

   assign req_fire = io_imem_req_valid && io_imem_req_ready;
   assign enq      = (state == WAIT) && io_imem_resp_valid && !io_redirect_valid;
   assign deq      = io_inst_valid && io_inst_ready;

   assign io_inst_valid = (count != '0);
   assign io_inst_pc    = q_pc[head];
   assign io_inst_bits  = q_bits[head];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         inflight_pc <= '0;
         head        <= '0;
         tail        <= '0;
         count       <= '0;
      end else if (io_redirect_valid) begin
         pc    <= io_redirect_target & ~32'h3;
         head  <= '0;
         tail  <= '0;
         count <= '0;
         // A response landing with the redirect closes the outstanding request, so no kill is needed.
         if ((state != IDLE) && io_imem_resp_valid) begin
            state <= IDLE;
         end else if (state == WAIT) begin
            state <= KILL;
         end
      end else begin
         if (req_fire) begin
            pc          <= pc + 32'd4;
            inflight_pc <= pc;
         end
         case (state)
            IDLE:    if (req_fire) state <= WAIT;
            WAIT:    if (io_imem_resp_valid) state <= IDLE;
            KILL:    if (io_imem_resp_valid) state <= IDLE;
            default: state <= IDLE;
         endcase
         if (enq) tail <= tail + 1'b1;
         if (deq) head <= head + 1'b1;
         case ({enq, deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (enq) begin
         q_pc[tail]   <= inflight_pc;
         q_bits[tail] <= io_imem_resp_data;
      end
   end

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: inputs driven at the falling edge, outputs checked 1 ns later.
module tb_ifetch_stage;

   logic        clock;
   logic        reset;
   logic        io_imem_req_valid;
   logic        io_imem_req_ready;
   logic [31:0] io_imem_req_addr;
   logic        io_imem_resp_valid;
   logic [31:0] io_imem_resp_data;
   logic        io_redirect_valid;
   logic [31:0] io_redirect_target;
   logic        io_inst_valid;
   logic        io_inst_ready;
   logic [31:0] io_inst_pc;
   logic [31:0] io_inst_bits;

   int checks = 0;
   int errors = 0;

   ifetch_stage dut (
      .clock              (clock),
      .reset              (reset),
      .io_imem_req_valid  (io_imem_req_valid),
      .io_imem_req_ready  (io_imem_req_ready),
      .io_imem_req_addr   (io_imem_req_addr),
      .io_imem_resp_valid (io_imem_resp_valid),
      .io_imem_resp_data  (io_imem_resp_data),
      .io_redirect_valid  (io_redirect_valid),
      .io_redirect_target (io_redirect_target),
      .io_inst_valid      (io_inst_valid),
      .io_inst_ready      (io_inst_ready),
      .io_inst_pc         (io_inst_pc),
      .io_inst_bits       (io_inst_bits)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] dword(input int i);
      return 32'hA000_0000 + 32'(i);
   endfunction

   initial begin
      reset              = 1'b1;
      io_imem_req_ready  = 1'b0;
      io_imem_resp_valid = 1'b0;
      io_imem_resp_data  = '0;
      io_redirect_valid  = 1'b0;
      io_redirect_target = '0;
      io_inst_ready      = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("rst_req_valid", 32'(io_imem_req_valid), 32'd0);
      chk("rst_inst_valid", 32'(io_inst_valid), 32'd0);
      repeat (2) @(negedge clock);

      // Release: first request must appear immediately at RESET_PC
      reset             = 1'b1;
      io_imem_req_ready = 1'b1;
      io_inst_ready     = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clock);
         io_imem_resp_valid = 1'b0;
         #1;
         chk("seq_req_valid", 32'(io_imem_req_valid), 32'd1);
         chk("seq_req_addr", io_imem_req_addr, 32'h8000_0000 + 32'(4 * i));
         if (i > 0) begin
            chk("seq_inst_valid", 32'(io_inst_valid), 32'd1);
            chk("seq_inst_pc", io_inst_pc, 32'h8000_0000 + 32'(4 * (i - 1)));
            chk("seq_inst_bits", io_inst_bits, dword(i - 1));
         end
         @(negedge clock);
         io_imem_resp_valid = 1'b1;
         io_imem_resp_data  = dword(i);
         #1;
         chk("wait_req_valid", 32'(io_imem_req_valid), 32'd0);
         chk("wait_inst_valid", 32'(io_inst_valid), 32'd0);
      end

      // Backpressure: fill the queue
      @(negedge clock);
      io_imem_resp_valid = 1'b0;
      io_inst_ready      = 1'b0;
      #1;
      chk("bp_inst_pc0", io_inst_pc, 32'h8000_0008);
      chk("bp_inst_bits0", io_inst_bits, dword(2));
      chk("bp_req_addr", io_imem_req_addr, 32'h8000_000C);
      chk("bp_req_valid", 32'(io_imem_req_valid), 32'd1);
      @(negedge clock);
      io_imem_resp_valid = 1'b1;
      io_imem_resp_data  = dword(3);
      @(negedge clock);
      io_imem_resp_valid = 1'b0;
      #1;
      chk("full_req_valid", 32'(io_imem_req_valid), 32'd0);
      chk("full_inst_pc", io_inst_pc, 32'h8000_0008);
      @(negedge clock);
      #1;
      chk("full_hold_req_valid", 32'(io_imem_req_valid), 32'd0);
      @(negedge clock);
      io_inst_ready = 1'b1;
      #1;
      chk("drain_req_valid", 32'(io_imem_req_valid), 32'd0);
      chk("drain_inst_bits", io_inst_bits, dword(2));
      @(negedge clock);
      #1;
      chk("resume_inst_pc", io_inst_pc, 32'h8000_000C);
      chk("resume_inst_bits", io_inst_bits, dword(3));
      chk("resume_req_valid", 32'(io_imem_req_valid), 32'd1);
      chk("resume_req_addr", io_imem_req_addr, 32'h8000_0010);
      @(negedge clock);
      io_imem_resp_valid = 1'b1;
      io_imem_resp_data  = dword(4);
      #1;
      chk("empty_inst_valid", 32'(io_inst_valid), 32'd0);
      @(negedge clock);
      io_imem_resp_valid = 1'b0;
      io_inst_ready      = 1'b0;
      #1;
      chk("r4_inst_pc", io_inst_pc, 32'h8000_0010);
      chk("r4_req_addr", io_imem_req_addr, 32'h8000_0014);

      // Simultaneous enqueue and dequeue at count==1
      @(negedge clock);
      io_imem_resp_valid = 1'b1;
      io_imem_resp_data  = dword(5);
      io_inst_ready      = 1'b1;
      @(negedge clock);
      io_imem_resp_valid = 1'b0;
      io_inst_ready      = 1'b0;
      #1;
      chk("encdeq_inst_valid", 32'(io_inst_valid), 32'd1);
      chk("encdeq_inst_pc", io_inst_pc, 32'h8000_0014);
      chk("encdeq_inst_bits", io_inst_bits, dword(5));
      chk("encdeq_req_valid", 32'(io_imem_req_valid), 32'd1);
      chk("encdeq_req_addr", io_imem_req_addr, 32'h8000_0018);

      // Redirect while WAIT: stale response must be killed
      @(negedge clock);
      io_redirect_valid  = 1'b1;
      io_redirect_target = 32'h0000_1003;
      #1;
      chk("redir_req_valid", 32'(io_imem_req_valid), 32'd0);
      @(negedge clock);
      io_redirect_valid = 1'b0;
      #1;
      chk("kill_inst_valid", 32'(io_inst_valid), 32'd0);
      chk("kill_req_valid", 32'(io_imem_req_valid), 32'd0);
      @(negedge clock);
      io_imem_resp_valid = 1'b1;
      io_imem_resp_data  = 32'hDEAD_BEEF;
      #1;
      chk("kill_resp_req_valid", 32'(io_imem_req_valid), 32'd0);
      @(negedge clock);
      io_imem_resp_valid = 1'b0;
      #1;
      chk("post_kill_inst_valid", 32'(io_inst_valid), 32'd0);
      chk("post_kill_req_valid", 32'(io_imem_req_valid), 32'd1);
      chk("post_kill_req_addr", io_imem_req_addr, 32'h0000_1000);
      @(negedge clock);
      io_imem_resp_valid = 1'b1;
      io_imem_resp_data  = dword(6);
      @(negedge clock);
      io_imem_resp_valid = 1'b0;
      #1;
      chk("tgt_inst_pc", io_inst_pc, 32'h0000_1000);
      chk("tgt_inst_bits", io_inst_bits, dword(6));
      chk("tgt_req_addr", io_imem_req_addr, 32'h0000_1004);

      // Redirect coincident with response and with a dequeue
      @(negedge clock);
      io_imem_resp_valid = 1'b1;
      io_imem_resp_data  = 32'hCAFE_F00D;
      io_redirect_valid  = 1'b1;
      io_redirect_target = 32'hFFFF_FFFC;
      io_inst_ready      = 1'b1;
      #1;
      chk("coinc_req_valid", 32'(io_imem_req_valid), 32'd0);
      @(negedge clock);
      io_imem_resp_valid = 1'b0;
      io_redirect_valid  = 1'b0;
      io_inst_ready      = 1'b0;
      #1;
      chk("coinc_inst_valid", 32'(io_inst_valid), 32'd0);
      chk("coinc_req_valid_next", 32'(io_imem_req_valid), 32'd1);
      chk("coinc_req_addr", io_imem_req_addr, 32'hFFFF_FFFC);
      @(negedge clock);
      io_imem_resp_valid = 1'b1;
      io_imem_resp_data  = dword(7);

      // PC wrap and request stall
      @(negedge clock);
      io_imem_resp_valid = 1'b0;
      io_imem_req_ready  = 1'b0;
      #1;
      chk("wrap_inst_pc", io_inst_pc, 32'hFFFF_FFFC);
      chk("wrap_inst_bits", io_inst_bits, dword(7));
      chk("wrap_req_addr", io_imem_req_addr, 32'h0000_0000);
      @(negedge clock);
      io_imem_req_ready = 1'b1;
      #1;
      chk("stall_req_valid", 32'(io_imem_req_valid), 32'd1);
      chk("stall_req_addr", io_imem_req_addr, 32'h0000_0000);
      @(negedge clock);
      io_imem_resp_valid = 1'b1;
      io_imem_resp_data  = dword(8);
      @(negedge clock);
      io_imem_resp_valid = 1'b0;
      io_inst_ready      = 1'b1;
      #1;
      chk("full2_req_valid", 32'(io_imem_req_valid), 32'd0);
      @(negedge clock);
      io_inst_ready = 1'b0;
      #1;
      chk("pre_rst_inst_pc", io_inst_pc, 32'h0000_0000);
      chk("pre_rst_inst_bits", io_inst_bits, dword(8));
      chk("pre_rst_req_addr", io_imem_req_addr, 32'h0000_0004);

      // Asynchronous reset during WAIT with an entry queued
      @(negedge clock);
      #3 reset = 1'b0;
      #1;
      chk("arst_inst_valid", 32'(io_inst_valid), 32'd0);
      chk("arst_req_valid", 32'(io_imem_req_valid), 32'd0);
      @(negedge clock);
      reset              = 1'b1;
      io_imem_req_ready  = 1'b0;
      io_imem_resp_valid = 1'b1;
      io_imem_resp_data  = 32'hBAD0_BAD0;
      #1;
      chk("rel_req_valid", 32'(io_imem_req_valid), 32'd1);
      chk("rel_req_addr", io_imem_req_addr, 32'h8000_0000);
      @(negedge clock);
      io_imem_resp_valid = 1'b0;
      io_imem_req_ready  = 1'b1;
      #1;
      chk("idle_resp_ignored", 32'(io_inst_valid), 32'd0);
      chk("rel_req_addr2", io_imem_req_addr, 32'h8000_0000);
      @(negedge clock);
      io_imem_resp_valid = 1'b1;
      io_imem_resp_data  = dword(9);
      @(negedge clock);
      io_imem_resp_valid = 1'b0;
      #1;
      chk("rel_inst_pc", io_inst_pc, 32'h8000_0000);
      chk("rel_inst_bits", io_inst_bits, dword(9));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ifetch_stage.md
IFETCH_STAGE -- requirements
Module: ifetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h80000000: first fetch address after reset.
REQ-002 Parameter QDEPTH, default 2: instruction queue entries; legal values are 2 or 4.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low; 0 resets all state immediately, independent of clock.
REQ-005 io_imem_req_valid  output  1  fetch request present.
REQ-006 io_imem_req_ready  input  1  memory accepts the request this cycle.
REQ-007 io_imem_req_addr  output  32  fetch address, word-aligned (bits[1:0]=0).
REQ-008 io_imem_resp_valid  input  1  response data valid; there is no ready, so the stage always accepts it.
REQ-009 io_imem_resp_data  input  32  fetched instruction word.
REQ-010 io_redirect_valid  input  1  flush and restart fetch at the target address.
REQ-011 io_redirect_target  input  32  new PC; bits[1:0] are ignored and forced to 0.
REQ-012 io_inst_valid  output  1  queue head is valid toward the core.
REQ-013 io_inst_ready  input  1  core consumes the head this cycle.
REQ-014 io_inst_pc  output  32  PC of the head entry.
REQ-015 io_inst_bits  output  32  instruction word of the head entry.

Function
REQ-016 At most one memory request outstanding; the FSM states are IDLE, WAIT and KILL.
REQ-017 io_imem_req_valid = (state==IDLE) & (count + 0 < QDEPTH) & ~io_redirect_valid; io_imem_req_addr = pc.
REQ-018 On req handshake (valid&ready): pc <= pc+4 (mod 2^32, wraps 0xFFFFFFFC->0), latch pc as inflight_pc, IDLE->WAIT.
REQ-019 While req_valid & ~req_ready, pc and addr stay stable until the handshake or a redirect.
REQ-020 WAIT & resp_valid & ~redirect: enqueue {inflight_pc, resp_data}, WAIT->IDLE.
REQ-021 KILL & resp_valid: discard the response, KILL->IDLE; no enqueue.
REQ-022 resp_valid in IDLE is a protocol error; the stage ignores it.
REQ-023 Request gating guarantees a free slot when a response arrives; the queue never overflows.
REQ-024 io_inst_valid = count!=0; head fields come straight from queue registers; dequeue on inst_valid&inst_ready.
REQ-025 Enqueue and dequeue in the same cycle keep count unchanged, including when count==QDEPTH-1 and when count==1.
REQ-026 Minimum latency: req handshake at cycle N, resp at N+k (k>=1), io_inst_valid high at N+k+1.
REQ-027 Redirect (highest priority): queue flushed (count<=0), pc <= target&~3; WAIT->KILL, IDLE->IDLE, KILL->KILL.
REQ-028 Redirect in the same cycle as a dequeue: the flush wins and the head is consumed-and-flushed; the core ignores the flushed head.
REQ-029 Redirect in the same cycle as resp_valid in WAIT: response discarded, state->IDLE (not KILL).
REQ-030 Fetch resumes at the target the cycle after the redirect at the earliest.
REQ-031 Queue pointers wrap modulo QDEPTH; count width = clog2(QDEPTH)+1.

Reset
REQ-032 While reset=0: pc=RESET_PC, state=IDLE, count=0, pointers=0, io_inst_valid=0, io_imem_req_valid=0.
REQ-033 Reset asserted mid-WAIT: in-flight response after release is dropped only if it arrives in IDLE (per REQ-022); the first post-reset request uses RESET_PC.
REQ-034 First request is presented in the first cycle after reset deassertion.

Verification
REQ-035 Reset release, req_ready=1, 1-cycle memory, inst_ready=1 -> addrs 0x80000000, 0x80000004, ... in order; io_inst_pc matches each word.
REQ-036 inst_ready=0, memory always ready -> exactly QDEPTH entries fill; req_valid stays 0; raising inst_ready resumes fetch with no loss or duplication.
REQ-037 Redirect to 0x00001003 while in WAIT -> stale response dropped; next request addr 0x00001000; no stale PC is ever output.
REQ-038 Redirect coincident with resp_valid -> response dropped, next cycle req_addr = target.
REQ-039 pc=0xFFFFFFFC fetch -> next request addr 0x00000000.
REQ-040 reset pulsed low asynchronously mid-WAIT with the queue full -> outputs clear immediately; after release, first req_addr=0x80000000.
